regfile_write_arbiter: RTL

- Shares the register file's single write port (write enable, write address, write data) between three sources:
  - the CPU writeback path;
  - a debug/loader requester using a valid/ready handshake;
  - a built-in clear sequencer that zeroes all 32 registers.
- Sits between the datapath/debug logic and the register file.
- The CPU path is combinational pass-through so single-cycle timing is preserved.
- A small FSM handles clear sequencing and debug starvation by stalling the CPU.

---
 rtl/regfile_write_arbiter.sv | 104 ++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register-file write port between CPU writeback, debug loader and a clear sequencer
module regfile_write_arbiter #(
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        cpu_we_i,
   input  logic [4:0]  cpu_addr_i,
   input  logic [31:0] cpu_wdata_i,
   input  logic        dbg_valid_i,
   input  logic [4:0]  dbg_addr_i,
   input  logic [31:0] dbg_wdata_i,
   output logic        dbg_ready_o,
   input  logic        clr_start_i,
   output logic        clr_busy_o,
   output logic        clr_done_o,
   output logic        cpu_stall_o,
   output logic        rf_we_o,
   output logic [4:0]  rf_a3_o,
   output logic [31:0] rf_wd3_o
);
   typedef enum logic [1:0] {IDLE, CLEAR, DBG_FORCE} state_t;
   state_t      state_q, state_d;
   logic [4:0]  clr_idx_q, clr_idx_d;
   logic [7:0]  starve_q, starve_d;
   logic        clr_done_q, clr_done_d;
   logic        cpu_ok, blocked;
   assign cpu_ok     = cpu_we_i && (cpu_addr_i != 5'd0);
   assign blocked    = dbg_valid_i && cpu_ok;
   assign clr_done_o = clr_done_q;
   // state, clear index, starvation counter and done pulse registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         clr_idx_q  <= '0;
         starve_q   <= '0;
         clr_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_idx_q  <= clr_idx_d;
         starve_q   <= starve_d;
         clr_done_q <= clr_done_d;
      end
   end
   // write-port mux, handshake and next-state logic; CPU path stays combinational
   always_comb begin
      state_d     = state_q;
      clr_idx_d   = clr_idx_q;
      starve_d    = starve_q;
      clr_done_d  = 1'b0;
      rf_we_o     = 1'b0;
      rf_a3_o     = '0;
      rf_wd3_o    = '0;
      dbg_ready_o = 1'b0;
      cpu_stall_o = 1'b0;
      clr_busy_o  = 1'b0;
      case (state_q)
         IDLE: begin
            if (cpu_ok) begin
               rf_we_o  = 1'b1;
               rf_a3_o  = cpu_addr_i;
               rf_wd3_o = cpu_wdata_i;
            end else if (dbg_valid_i) begin
               dbg_ready_o = 1'b1;
               rf_we_o     = dbg_addr_i != 5'd0;
               rf_a3_o     = dbg_addr_i;
               rf_wd3_o    = dbg_wdata_i;
            end
            starve_d = blocked ? ((starve_q == 8'hFF) ? starve_q : starve_q + 8'd1) : 8'd0;
            if (clr_start_i) begin
               state_d   = CLEAR;
               clr_idx_d = '0;
               starve_d  = '0;
            end else if (blocked && ({1'b0, starve_q} + 9'd1 >= 9'(STARVE_LIMIT))) begin
               state_d = DBG_FORCE;
            end
         end
         DBG_FORCE: begin
            cpu_stall_o = 1'b1;
            if (dbg_valid_i) begin
               dbg_ready_o = 1'b1;
               rf_we_o     = dbg_addr_i != 5'd0;
               rf_a3_o     = dbg_addr_i;
               rf_wd3_o    = dbg_wdata_i;
            end
            starve_d = '0;
            state_d  = IDLE;
         end
         CLEAR: begin
            cpu_stall_o = 1'b1;
            clr_busy_o  = 1'b1;
            rf_we_o     = 1'b1;
            rf_a3_o     = clr_idx_q;
            clr_idx_d   = clr_idx_q + 5'd1;
            starve_d    = '0;
            if (clr_idx_q == 5'd31) begin
               state_d    = IDLE;
               clr_done_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end
endmodule
